// File: rtl/sram_like_slave.sv
// sram_like_slave: responder for the class-SRAM req/addr_ok/data_ok bus.
// Requests are accepted into an in-order FIFO, and memory side effects happen at
// accept time. Each entry returns one data_ok pulse after a programmable latency.
// Optional LFSR stalls add extra delay to addr_ok and data_ok.
module sram_like_slave #(
    parameter int          AW       = 12,
    parameter int          DEPTH    = 2,
    parameter int          DATA_LAT = 1,
    parameter int          ADDR_GAP = 0,
    parameter int          RAND_EN  = 0,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    typedef struct packed {
        logic        vld;
        logic        is_wr;
        logic [31:0] data;
        logic [3:0]  lat_cnt;
    } entry_t;

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);
    localparam logic [3:0] LAT_C   = 4'(DATA_LAT - 1);
    localparam logic [3:0] GAP_C   = 4'(ADDR_GAP);
    localparam logic [1:0] LAST_C  = 2'(DEPTH - 1);

    logic [31:0]   mem [0:(1<<AW)-1];
    // Sized for the largest legal DEPTH so 2-bit pointers index it exactly.
    // Only the first DEPTH slots are ever used.
    entry_t        fifo [4];
    logic [1:0]    wptr, rptr;
    logic [2:0]    count;
    logic [3:0]    gap_cnt;
    logic [15:0]   lfsr;
    logic [AW-1:0] idx;
    logic          push, pop;
    entry_t        head;
    logic          unused;

    assign idx    = addr[AW+1:2];
    assign head   = fifo[rptr];
    assign push   = req && addr_ok;
    assign pop    = data_ok;
    // The transfer size and the bits outside the word index are deliberately unused.
    assign unused = ^{size, addr[31:AW+2], addr[1:0]};

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == LAST_C) ? 2'd0 : p + 2'd1;
    endfunction

    // Outputs come from registered state only. They are forced low while in reset.
    always_comb begin
        addr_ok = resetn && (count < DEPTH_C) && (gap_cnt == 4'd0) &&
                  ((RAND_EN == 0) || lfsr[0]);
        data_ok = resetn && head.vld && (head.lat_cnt == 4'd0) &&
                  ((RAND_EN == 0) || lfsr[1]);
        rdata   = (resetn && head.vld && !head.is_wr) ? head.data : 32'h0;
    end

    // Byte-masked memory write at accept time. Contents are kept across reset.
    always_ff @(posedge clk) begin
        if (push && wr) begin
            for (int i = 0; i < 4; i++)
                if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    // Queue state, latency countdown, address gap and stall LFSR.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count   <= 3'd0;
            wptr    <= 2'd0;
            rptr    <= 2'd0;
            gap_cnt <= 4'd0;
            lfsr    <= SEED;
            for (int j = 0; j < 4; j++) fifo[j].vld <= 1'b0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

            if (push)                gap_cnt <= GAP_C;
            else if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;

            for (int j = 0; j < 4; j++)
                if (fifo[j].vld && fifo[j].lat_cnt != 4'd0)
                    fifo[j].lat_cnt <= fifo[j].lat_cnt - 4'd1;

            if (pop) begin
                fifo[rptr].vld <= 1'b0;
                rptr           <= nxt(rptr);
            end

            // A push never targets the head slot while it pops:
            // a push needs count < DEPTH, and a pop needs count > 0.
            if (push) begin
                fifo[wptr] <= '{vld: 1'b1, is_wr: wr, data: mem[idx], lat_cnt: LAT_C};
                wptr       <= nxt(wptr);
            end

            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_like_slave.sv
// Directed bench for sram_like_slave. Five instances cover the defaults, full,
// gap, reset-mid-flight and random-stall configurations. They share one input bus.
module tb_sram_like_slave;

    logic        clk = 0;
    logic        resetn = 0;
    logic        req = 0, wr = 0;
    logic [1:0]  size = 2'b10;
    logic [3:0]  wstrb = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [4:0]  aok, dok;
    logic [31:0] rd [5];

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    sram_like_slave u0 (.clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size),
        .wstrb(wstrb), .addr(addr), .wdata(wdata), .addr_ok(aok[0]), .data_ok(dok[0]), .rdata(rd[0]));
    sram_like_slave #(.DEPTH(2), .DATA_LAT(3)) u1 (.clk(clk), .resetn(resetn), .req(req), .wr(wr),
        .size(size), .wstrb(wstrb), .addr(addr), .wdata(wdata), .addr_ok(aok[1]), .data_ok(dok[1]), .rdata(rd[1]));
    sram_like_slave #(.ADDR_GAP(2)) u2 (.clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size),
        .wstrb(wstrb), .addr(addr), .wdata(wdata), .addr_ok(aok[2]), .data_ok(dok[2]), .rdata(rd[2]));
    sram_like_slave #(.DATA_LAT(4)) u3 (.clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size),
        .wstrb(wstrb), .addr(addr), .wdata(wdata), .addr_ok(aok[3]), .data_ok(dok[3]), .rdata(rd[3]));
    sram_like_slave #(.RAND_EN(1), .DEPTH(4), .DATA_LAT(2)) u4 (.clk(clk), .resetn(resetn), .req(req),
        .wr(wr), .size(size), .wstrb(wstrb), .addr(addr), .wdata(wdata), .addr_ok(aok[4]), .data_ok(dok[4]), .rdata(rd[4]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge, then return at mid-cycle.
    task automatic step(input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d);
        @(posedge clk); #1;
        req = r; wr = w; addr = a; wstrb = s; wdata = d;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        resetn = 0; req = 0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("rst_aok", 32'(aok[k]), 0);
            chk("rst_dok", 32'(dok[k]), 0);
            chk("rst_rdata", rd[k], 0);
        end
        repeat (2) @(posedge clk);
        #1 resetn = 1;
        @(negedge clk);
        chk("post_rst_aok", 32'(aok[0]), 1);
        chk("post_rst_dok", 32'(dok[0]), 0);
    endtask

    // Random-phase scoreboard.
    bit          rnd_on = 0, seen_idle = 0;
    int          n_acc = 0, n_dok = 0;
    logic [31:0] model [8];
    logic [31:0] q [$];

    always @(negedge clk) begin
        if (rnd_on) begin
            if (dok[4]) begin
                if (q.size() == 0) chk("rnd_extra_dok", 1, 0);
                else begin
                    chk("rnd_rdata", rd[4], q.pop_front());
                    n_dok++;
                end
            end
            if (req && aok[4]) begin
                n_acc++;
                if (wr) begin
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) model[addr[4:2]][8*b +: 8] = wdata[8*b +: 8];
                    q.push_back(32'h0);
                end else q.push_back(model[addr[4:2]]);
            end
            if (!req && aok[4]) seen_idle = 1;
        end
    end

    task automatic send(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        bit done = 0;
        @(posedge clk); #1;
        req = 1; wr = w; addr = a; wstrb = s; wdata = d;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (aok[4]) done = 1;
        end
        if (!done) chk("send_timeout", 0, 1);
        @(posedge clk); #1 req = 0;
    endtask

    logic [7:0] t3_aok = 8'b0011_0011; // bit i = cycle t+i
    logic [7:0] t3_dok = 8'b1001_1000;
    logic [6:0] t4_aok = 7'b100_1001;

    initial begin
        // Single read after loading mem[5]; write response carries rdata 0.
        do_reset();
        step(1, 1, 32'h14, 4'hF, 32'h12345678); chk("t1_wr_aok", 32'(aok[0]), 1);
        step(1, 0, 32'h14, 4'h0, 32'h0);        chk("t1_rd_aok", 32'(aok[0]), 1);
        chk("t1_wr_dok", 32'(dok[0]), 1);       chk("t1_wr_rdata", rd[0], 0);
        step(0, 0, 0, 0, 0);                     chk("t1_rd_dok", 32'(dok[0]), 1);
        chk("t1_rd_rdata", rd[0], 32'h12345678);
        step(0, 0, 0, 0, 0);                     chk("t1_idle_dok", 32'(dok[0]), 0);

        // Partial write over an old value, then read back.
        step(1, 1, 32'h20, 4'hF, 32'h11223344);
        step(1, 1, 32'h20, 4'b0101, 32'hAABBCCDD);
        step(1, 0, 32'h20, 4'h0, 32'h0);
        chk("t2_pwr_dok", 32'(dok[0]), 1);      chk("t2_pwr_rdata", rd[0], 0);
        step(0, 0, 0, 0, 0);
        chk("t2_rd_dok", 32'(dok[0]), 1);       chk("t2_rd_rdata", rd[0], 32'h11BB33DD);

        // Full / back-pressure with DEPTH=2 and DATA_LAT=3.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 32'h40, 4'h0, 32'h0);
            chk($sformatf("t3_aok_%0d", i), 32'(aok[1]), 32'(t3_aok[i]));
            chk($sformatf("t3_dok_%0d", i), 32'(dok[1]), 32'(t3_dok[i]));
        end

        // Gap of 2 cycles between accepts.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 32'h40, 4'h0, 32'h0);
            chk($sformatf("t4_aok_%0d", i), 32'(aok[2]), 32'(t4_aok[i]));
        end

        // Reset mid-flight with DATA_LAT=4: the pending read must vanish.
        do_reset();
        step(1, 0, 32'h80, 4'h0, 32'h0);         chk("t5_aok", 32'(aok[3]), 1);
        @(posedge clk); #1 resetn = 0; req = 0;
        @(negedge clk);
        chk("t5_rst_aok", 32'(aok[3]), 0);       chk("t5_rst_dok", 32'(dok[3]), 0);
        @(posedge clk); #1 resetn = 1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t5_dok_%0d", i), 32'(dok[3]), 0);
            step(0, 0, 0, 0, 0);
        end

        // Random stalls against the scoreboard.
        do_reset();
        rnd_on = 1;
        for (int w = 0; w < 8; w++) send(1, 32'(w) << 2, 4'hF, $urandom());
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            a = ($urandom() & 32'hFFFF_C000) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            send(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom());
            repeat ($urandom_range(0, 2)) step(0, 0, 0, 0, 0);
        end
        for (int k = 0; k < 300 && q.size() != 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("rnd_drain", 32'(q.size()), 0);
        chk("rnd_acc_cnt", 32'(n_acc), 208);
        chk("rnd_dok_cnt", 32'(n_dok), 32'(n_acc));
        chk("rnd_idle_aok", 32'(seen_idle), 1);
        rnd_on = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
